invert_lane_pipe: RTL and testbench

Parametrised, handshaked bit-manipulation pipeline, the next generation of the team's fixed 32-bit inversion/XOR datapath. It splits each input word into lanes and applies one of four runtime-selected operations: invert, inverted-pair OR, pair XOR, or half-compare. Results leave through a 2-stage valid/ready pipeline. The block sits between a word-stream producer and consumer and also keeps a saturating count of half-match events.

---
 rtl/invert_lane_pipe.sv | 134 +++++++++++++
 tb/tb_invert_lane_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/invert_lane_pipe.sv
// Lane-wise invert / inverted-pair OR / pair XOR / half-compare datapath behind a 2-stage valid/ready pipe.
// Optional out_parity output (even parity of out_data) when INVERT_PIPE_PARITY_EN is defined.
module invert_lane_pipe #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
`ifdef INVERT_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int N = WIDTH / LANE;
  localparam int H = WIDTH / 2;

  localparam logic [1:0] MODE_INV  = 2'b00;
  localparam logic [1:0] MODE_NORP = 2'b01;
  localparam logic [1:0] MODE_XORP = 2'b10;
  localparam logic [1:0] MODE_HALF = 2'b11;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic             s2_valid;

  logic [H-1:0]     s1_hi;
  logic [H-1:0]     s1_lo;
  logic [WIDTH-1:0] result;
  logic             s1_eq;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;

  // S2 can take a new beat when empty or when its current beat leaves this cycle.
  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign s1_hi = s1_data[WIDTH-1:H];
  assign s1_lo = s1_data[H-1:0];
  assign s1_eq = (s1_mode == MODE_HALF) && (s1_hi == s1_lo);

  always_comb begin
    result = '0;
    case (s1_mode)
      MODE_INV: result = ~s1_data;
      MODE_NORP: begin
        for (int i = 0; i < N; i++) begin
          result[i*LANE +: LANE] = ~s1_data[i*LANE +: LANE] | ~s1_data[((i + 1) % N)*LANE +: LANE];
        end
      end
      MODE_XORP: begin
        for (int i = 0; i < N; i++) begin
          result[i*LANE +: LANE] = s1_data[i*LANE +: LANE] ^ s1_data[((i + 1) % N)*LANE +: LANE];
        end
      end
      default: begin
        result[H-1:0] = s1_lo;
        if (s1_hi == s1_lo) begin
          result[WIDTH-1:H] = ~s1_lo;
        end else begin
          result[WIDTH-1:H] = {{(H-1){1'b0}}, ^s1_hi};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_INV;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_mode  <= in_mode;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        out_data <= result;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle increment; counting stops at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (s1_adv && s1_eq && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef INVERT_PIPE_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (s1_adv) begin
      out_parity <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_invert_lane_pipe.sv
// Randomised + directed bench for invert_lane_pipe against a queue-based reference model.
module tb_invert_lane_pipe;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        cnt_clr;
  logic [CNT_W-1:0] match_cnt;
`ifdef INVERT_PIPE_PARITY_EN
  logic        out_parity;
`endif

  invert_lane_pipe #(.WIDTH(32), .LANE(8), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mode(in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .cnt_clr(cnt_clr),
    .match_cnt(match_cnt)
`ifdef INVERT_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    int          id;
    int          age;
    bit          has_lit;
    logic [31:0] lit;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    next_id = 0;
  int    last_s2 = -1;
  int    mcnt = 0;
  int    dut_pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] d, input logic [1:0] m);
    logic [7:0]  ln[4];
    logic [7:0]  t;
    logic [31:0] r;
    logic [15:0] hi;
    logic [15:0] lo;
    for (int i = 0; i < 4; i++) ln[i] = 8'((d >> (8 * i)) & 32'hFF);
    hi = 16'(d >> 16);
    lo = 16'(d & 32'hFFFF);
    r = 32'h0;
    case (m)
      2'd0: r = d ^ 32'hFFFF_FFFF;
      2'd1: for (int i = 0; i < 4; i++) begin
              t = ~(ln[i] & ln[(i + 1) % 4]);
              r = r | (32'(t) << (8 * i));
            end
      2'd2: for (int i = 0; i < 4; i++) begin
              t = ln[i] ^ ln[(i + 1) % 4];
              r = r | (32'(t) << (8 * i));
            end
      default: begin
        if (hi == lo) r = (32'(16'hFFFF - lo) << 16) | 32'(lo);
        else          r = (32'($countones(hi) % 2) << 16) | 32'(lo);
      end
    endcase
    return r;
  endfunction

  function automatic bit is_eq(input beat_t b);
    return (b.mode == 2'd3) && (b.data[31:16] == b.data[15:0]);
  endfunction

  task automatic compare();
    bit          exp_ov;
    logic [31:0] e;
    exp_ov = (q.size() > 0) && (q[0].age >= 2);
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    chk("out_valid", out_valid, exp_ov);
    chk("match_cnt", match_cnt, mcnt);
    if (exp_ov) begin
      e = ref_op(q[0].data, q[0].mode);
      chk("out_data", out_data, e);
      if (q[0].has_lit) chk("out_data_literal", out_data, q[0].lit);
`ifdef INVERT_PIPE_PARITY_EN
      chk("out_parity", out_parity, ^e);
`endif
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at the following negedge.
  task automatic step(input bit v, input logic [31:0] d, input logic [1:0] m, input bit ordy,
                      input bit clr, input bit r, input bit has_lit, input logic [31:0] lit,
                      output bit acc);
    bit    exp_rdy;
    bit    exp_ov;
    bit    pop;
    beat_t nb;
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; cnt_clr = clr; rst = r;
    exp_rdy = !(q.size() == 2 && !ordy);
    exp_ov  = (q.size() > 0) && (q[0].age >= 2);
    acc     = v && exp_rdy && !r;
    pop     = exp_ov && ordy;
    if (out_valid && ordy && !r) dut_pops++;
    @(posedge clk);
    if (r) begin
      q.delete();
      mcnt = 0;
    end else begin
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      if (pop) void'(q.pop_front());
      if (acc) begin
        nb.data = d; nb.mode = m; nb.id = next_id; nb.age = 1; nb.has_lit = has_lit; nb.lit = lit;
        next_id++;
        q.push_back(nb);
      end
      if (q.size() > 0 && q[0].age >= 2 && q[0].id != last_s2) begin
        last_s2 = q[0].id;
        if (!clr && is_eq(q[0]) && mcnt < CMAX) mcnt++;
      end
      if (clr) mcnt = 0;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(0, 32'h0, 2'd0, ordy, 0, 0, 0, 32'h0, a);
  endtask

  initial begin
    bit          a;
    bit          saw_low;
    int          sent;
    int          pops0;
    logic [31:0] d;
    logic [1:0]  m;
    in_valid = 0; in_data = 0; in_mode = 0; out_ready = 0; cnt_clr = 0; rst = 1;

    step(0, 32'h0, 2'd0, 1, 0, 1, 0, 32'h0, a);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_match_cnt", match_cnt, 0);
`ifdef INVERT_PIPE_PARITY_EN
    chk("reset_out_parity", out_parity, 1'b0);
`endif

    step(1, 32'h000000FF, 2'd0, 1, 0, 0, 1, 32'hFFFFFF00, a);
    step(0, 32'h0, 2'd0, 1, 0, 0, 0, 32'h0, a);
    chk("inv_latency_out_valid", out_valid, 1'b1);
    chk("inv_out_data", out_data, 32'hFFFFFF00);
`ifdef INVERT_PIPE_PARITY_EN
    chk("inv_out_parity", out_parity, 1'b0);
`endif
    step(1, 32'h12345678, 2'd2, 1, 0, 0, 1, 32'h6A26622E, a);
    step(1, 32'hF0F00F0F, 2'd1, 1, 0, 0, 1, 32'hFF0FFFF0, a);
    step(1, 32'hA5A5A5A5, 2'd3, 1, 0, 0, 1, 32'h5A5AA5A5, a);
    idle(3, 1);
    chk("half_eq_cnt", match_cnt, 1);
    step(1, 32'h00010000, 2'd3, 1, 0, 0, 1, 32'h00010000, a);
    idle(3, 1);
    chk("half_ne_cnt", match_cnt, 1);
    step(1, 32'hA5A5A5A5, 2'd3, 1, 0, 0, 1, 32'h5A5AA5A5, a);
    step(0, 32'h0, 2'd0, 1, 1, 0, 0, 32'h0, a);
    chk("clr_priority_cnt", match_cnt, 0);
    idle(2, 1);

    // Stream 0..5 in INV mode with a three-cycle consumer stall.
    sent = 0; saw_low = 0; pops0 = dut_pops;
    for (int c = 0; c < 16; c++) begin
      if (!in_ready) saw_low = 1;
      step(sent < 6, 32'(sent), 2'd0, !(c >= 2 && c <= 4), 0, 0, 1, ~32'(sent), a);
      if (a) sent++;
    end
    chk("stream_in_ready_dropped", saw_low, 1'b1);
    chk("stream_result_count", dut_pops - pops0, 6);

    // Reset with a full pipe and a nonzero counter.
    step(1, 32'h3C3C3C3C, 2'd3, 0, 0, 0, 0, 32'h0, a);
    step(1, 32'h77777777, 2'd3, 0, 0, 0, 0, 32'h0, a);
    idle(1, 0);
    chk("pre_rst_cnt", match_cnt, 1);
    step(0, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, a);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_cnt", match_cnt, 0);
    idle(4, 1);

    for (int i = 0; i < 20; i++) step(1, 32'h5E5E5E5E, 2'd3, 1, 0, 0, 0, 32'h0, a);
    idle(3, 1);
    chk("saturate_cnt", match_cnt, CMAX);

    step(0, 32'h0, 2'd0, 1, 0, 1, 0, 32'h0, a);
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) d = {d[15:0], d[15:0]};
      step($urandom_range(0, 9) < 7, d, m, $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0, 0, 32'h0, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
